dmem_upg_loader: RTL

DMEM_UPG_LOADER -- requirements
Module: dmem_upg_loader

---
 rtl/dmem_upg_loader_if.sv | 50 +++++
 rtl/dmem_upg_loader.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/dmem_upg_loader_if.sv
// dmem_upg_loader_if: byte-stream receive handshake plus the data-memory
// upgrade write port driven by the loader.
//
// Signals
//   rx_valid_i  byte on rx_data_i is valid (driven by the byte source)
//   rx_data_i   incoming byte
//   rx_ready_o  loader accepts a byte this cycle
//   upg_wen_o   one-cycle write strobe to the memory upgrade port
//   upg_adr_o   word address of the current write (ADDR_W bits)
//   upg_dat_o   assembled 32-bit write word
//   upg_done_o  load complete, memory handed back to the CPU
//   err_o       checksum mismatch flag
//
// Modports
//   master  byte source / memory observer side
//   slave   the loader itself
interface dmem_upg_loader_if #(
    parameter int ADDR_W = 14
);
    logic              rx_valid_i;
    logic [7:0]        rx_data_i;
    logic              rx_ready_o;
    logic              upg_wen_o;
    logic [ADDR_W-1:0] upg_adr_o;
    logic [31:0]       upg_dat_o;
    logic              upg_done_o;
    logic              err_o;

    modport master (
        output rx_valid_i,
        output rx_data_i,
        input  rx_ready_o,
        input  upg_wen_o,
        input  upg_adr_o,
        input  upg_dat_o,
        input  upg_done_o,
        input  err_o
    );

    modport slave (
        input  rx_valid_i,
        input  rx_data_i,
        output rx_ready_o,
        output upg_wen_o,
        output upg_adr_o,
        output upg_dat_o,
        output upg_done_o,
        output err_o
    );
endinterface

// File: rtl/dmem_upg_loader.sv
// dmem_upg_loader: receives a byte stream (2-byte little-endian word count N,
// then 4*N little-endian data bytes) and writes the words to data memory
// at consecutive addresses 0..N-1 through the upgrade port, then sets done.
//
// Ports
//   upg_clk_i  clock, all state changes on its rising edge
//   upg_rst_i  asynchronous active-high reset, aborts any load in progress
//   bus        dmem_upg_loader_if.slave (rx handshake + upgrade write port)
//
// Parameter
//   ADDR_W     word-address width of the target memory (1..16)
//
// Build option
//   LOADER_CHECKSUM_EN  when defined, one trailing checksum byte (XOR of all
//                       header and data bytes) is received; a mismatch sets
//                       err_o, sticky until reset. When undefined err_o is 0.
module dmem_upg_loader #(
    parameter int ADDR_W = 14
) (
    input logic              upg_clk_i,
    input logic              upg_rst_i,
    dmem_upg_loader_if.slave bus
);

`ifdef LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        HDR0, HDR1, DATA, WRITE, CSUM, DONE
    } state_t;
`else
    typedef enum logic [2:0] {
        HDR0, HDR1, DATA, WRITE, DONE
    } state_t;
`endif

    state_t            state_q;
    logic [7:0]        nlo_q;
    logic [ADDR_W-1:0] n_q;
    logic [ADDR_W-1:0] adr_q;
    logic [1:0]        idx_q;
    logic [23:0]       word_q;
    logic [31:0]       dat_q;
    logic              ready_q;
    logic              wen_q;
    logic              done_q;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]        csum_q;
    logic              err_q;
`endif

    logic              xfer;
    logic [15:0]       hdr_w;
    logic [ADDR_W-1:0] n_d;
    logic [ADDR_W-1:0] adr_d;
    logic              unused_hdr;

    // ready_q is a registered copy of "state accepts bytes", so a transfer
    // is simply valid & ready as seen by the source.
    assign xfer  = bus.rx_valid_i & ready_q;

    // Header bits above ADDR_W are ignored.
    assign hdr_w      = {bus.rx_data_i, nlo_q};
    assign n_d        = hdr_w[ADDR_W-1:0];
    assign unused_hdr = ^hdr_w;
    assign adr_d      = adr_q + ADDR_W'(1);

    always_ff @(posedge upg_clk_i or posedge upg_rst_i) begin
        if (upg_rst_i) begin
            state_q <= HDR0;
            nlo_q   <= '0;
            n_q     <= '0;
            adr_q   <= '0;
            idx_q   <= '0;
            word_q  <= '0;
            dat_q   <= '0;
            ready_q <= 1'b0;
            wen_q   <= 1'b0;
            done_q  <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            csum_q  <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            wen_q <= 1'b0;

`ifdef LOADER_CHECKSUM_EN
            // Header and data bytes feed the running XOR; the checksum
            // byte itself is compared, not accumulated.
            if (xfer && state_q != CSUM) begin
                csum_q <= csum_q ^ bus.rx_data_i;
            end
`endif

            unique case (state_q)
                HDR0: begin
                    // First edge after reset raises ready.
                    ready_q <= 1'b1;
                    if (xfer) begin
                        nlo_q   <= bus.rx_data_i;
                        state_q <= HDR1;
                    end
                end

                HDR1: begin
                    if (xfer) begin
                        n_q <= n_d;
                        if (n_d == '0) begin
`ifdef LOADER_CHECKSUM_EN
                            state_q <= CSUM;
`else
                            state_q <= DONE;
                            ready_q <= 1'b0;
                            done_q  <= 1'b1;
`endif
                        end else begin
                            state_q <= DATA;
                        end
                    end
                end

                DATA: begin
                    if (xfer) begin
                        idx_q <= idx_q + 2'd1;
                        unique case (idx_q)
                            2'd0: word_q[7:0]   <= bus.rx_data_i;
                            2'd1: word_q[15:8]  <= bus.rx_data_i;
                            2'd2: word_q[23:16] <= bus.rx_data_i;
                            2'd3: begin
                                dat_q   <= {bus.rx_data_i, word_q};
                                wen_q   <= 1'b1;
                                ready_q <= 1'b0;
                                state_q <= WRITE;
                            end
                            default: ;
                        endcase
                    end
                end

                WRITE: begin
                    // adr_q still holds this write's address; advance after.
                    adr_q <= adr_d;
                    if (adr_d == n_q) begin
`ifdef LOADER_CHECKSUM_EN
                        state_q <= CSUM;
                        ready_q <= 1'b1;
`else
                        state_q <= DONE;
                        done_q  <= 1'b1;
`endif
                    end else begin
                        state_q <= DATA;
                        ready_q <= 1'b1;
                    end
                end

`ifdef LOADER_CHECKSUM_EN
                CSUM: begin
                    if (xfer) begin
                        if (bus.rx_data_i != csum_q) begin
                            err_q <= 1'b1;
                        end
                        state_q <= DONE;
                        ready_q <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
`endif

                DONE: begin
                    ready_q <= 1'b0;
                    done_q  <= 1'b1;
                end

                default: begin
                    state_q <= HDR0;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.rx_ready_o = ready_q;
    assign bus.upg_wen_o  = wen_q;
    assign bus.upg_adr_o  = adr_q;
    assign bus.upg_dat_o  = dat_q;
    assign bus.upg_done_o = done_q;
`ifdef LOADER_CHECKSUM_EN
    assign bus.err_o      = err_q;
`else
    assign bus.err_o      = 1'b0;
`endif

endmodule
